// File: rtl/sprite_motion_ctrl.sv
// Per-frame sprite position controller: debounces four push keys, steps the sprite
// once per frame inside a clamp window and reverts to the last collision-free spot.
module sprite_motion_ctrl #(
  parameter int XW         = 11,
  parameter int YW         = 11,
  parameter int X_INIT     = 80,
  parameter int Y_INIT     = 80,
  parameter int X_MIN      = 20,
  parameter int X_MAX      = 800,
  parameter int Y_MIN      = 24,
  parameter int Y_MAX      = 456,
  parameter int STEP       = 1,
  parameter int DEB_FRAMES = 3
) (
  input  logic          pixelCLK,
  input  logic          RESET_N,
  input  logic          enable,
  input  logic          frame_tick,
  input  logic [3:0]    KEY_N,
  input  logic          collide,
  output logic [XW-1:0] img_x,
  output logic [YW-1:0] img_y,
  output logic          collided,
  output logic          moving,
  output logic          overrun,
  output logic [7:0]    collide_cnt
);

  localparam logic [1:0] S_WAIT = 2'd0;
  localparam logic [1:0] S_EVAL = 2'd1;
  localparam logic [1:0] S_MOVE = 2'd2;

  localparam logic [3:0]    DEB      = 4'(DEB_FRAMES);
  localparam logic [XW-1:0] X_INIT_N = XW'(X_INIT);
  localparam logic [YW-1:0] Y_INIT_N = YW'(Y_INIT);
  localparam logic [XW-1:0] X_MIN_N  = XW'(X_MIN);
  localparam logic [XW-1:0] X_MAX_N  = XW'(X_MAX);
  localparam logic [YW-1:0] Y_MIN_N  = YW'(Y_MIN);
  localparam logic [YW-1:0] Y_MAX_N  = YW'(Y_MAX);
  localparam logic [XW-1:0] X_STEP_N = XW'(STEP);
  localparam logic [YW-1:0] Y_STEP_N = YW'(STEP);
  // Thresholds carry one extra bit so the clamp test can never wrap.
  localparam logic [XW:0]   X_LO_W   = (XW+1)'(X_MIN + STEP);
  localparam logic [XW:0]   X_HI_W   = (XW+1)'(X_MAX - STEP);
  localparam logic [YW:0]   Y_LO_W   = (YW+1)'(Y_MIN + STEP);
  localparam logic [YW:0]   Y_HI_W   = (YW+1)'(Y_MAX - STEP);

  logic [1:0]      state_q, state_d;
  logic [3:0]      key_meta_q, key_meta_d;
  logic [3:0]      key_sync_q, key_sync_d;
  logic [3:0][3:0] deb_cnt_q, deb_cnt_d;
  logic [XW-1:0]   img_x_q, img_x_d, good_x_q, good_x_d;
  logic [YW-1:0]   img_y_q, img_y_d, good_y_q, good_y_d;
  logic            collided_q, collided_d;
  logic            overrun_q, overrun_d;
  logic [7:0]      collide_cnt_q, collide_cnt_d;

  logic [3:0]      pressed;
  logic [3:0]      held;
  logic [XW-1:0]   x_dec, x_inc;
  logic [YW-1:0]   y_dec, y_inc;

  assign pressed = ~key_sync_q;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      held[k] = (deb_cnt_q[k] == DEB);
    end
  end

  assign x_dec = ({1'b0, img_x_q} >= X_LO_W) ? (img_x_q - X_STEP_N) : X_MIN_N;
  assign x_inc = ({1'b0, img_x_q} <= X_HI_W) ? (img_x_q + X_STEP_N) : X_MAX_N;
  assign y_dec = ({1'b0, img_y_q} >= Y_LO_W) ? (img_y_q - Y_STEP_N) : Y_MIN_N;
  assign y_inc = ({1'b0, img_y_q} <= Y_HI_W) ? (img_y_q + Y_STEP_N) : Y_MAX_N;

  always_comb begin
    key_meta_d    = KEY_N;
    key_sync_d    = key_meta_q;
    deb_cnt_d     = deb_cnt_q;
    state_d       = state_q;
    img_x_d       = img_x_q;
    img_y_d       = img_y_q;
    good_x_d      = good_x_q;
    good_y_d      = good_y_q;
    collided_d    = 1'b0;
    collide_cnt_d = collide_cnt_q;
    overrun_d     = overrun_q | (frame_tick & (state_q != S_WAIT));

    if (frame_tick) begin
      for (int k = 0; k < 4; k++) begin
        if (!pressed[k])          deb_cnt_d[k] = 4'd0;
        else if (deb_cnt_q[k] != DEB) deb_cnt_d[k] = deb_cnt_q[k] + 4'd1;
      end
    end

    case (state_q)
      S_WAIT: begin
        if (frame_tick && enable) state_d = S_EVAL;
      end
      S_EVAL: begin
        if (collide) begin
          img_x_d    = good_x_q;
          img_y_d    = good_y_q;
          collided_d = 1'b1;
          if (collide_cnt_q != 8'hFF) collide_cnt_d = collide_cnt_q + 8'd1;
          state_d    = S_WAIT;
        end else begin
          good_x_d = img_x_q;
          good_y_d = img_y_q;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        // Up beats down and left beats right; the two axes are independent.
        if (held[3])      img_y_d = y_dec;
        else if (held[2]) img_y_d = y_inc;
        if (held[1])      img_x_d = x_dec;
        else if (held[0]) img_x_d = x_inc;
        state_d = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

  always_ff @(posedge pixelCLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= S_WAIT;
      key_meta_q    <= 4'hF;
      key_sync_q    <= 4'hF;
      deb_cnt_q     <= '0;
      img_x_q       <= X_INIT_N;
      img_y_q       <= Y_INIT_N;
      good_x_q      <= X_INIT_N;
      good_y_q      <= Y_INIT_N;
      collided_q    <= 1'b0;
      overrun_q     <= 1'b0;
      collide_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      key_meta_q    <= key_meta_d;
      key_sync_q    <= key_sync_d;
      deb_cnt_q     <= deb_cnt_d;
      img_x_q       <= img_x_d;
      img_y_q       <= img_y_d;
      good_x_q      <= good_x_d;
      good_y_q      <= good_y_d;
      collided_q    <= collided_d;
      overrun_q     <= overrun_d;
      collide_cnt_q <= collide_cnt_d;
    end
  end

  assign img_x       = img_x_q;
  assign img_y       = img_y_q;
  assign collided    = collided_q;
  assign moving      = |held;
  assign overrun     = overrun_q;
  assign collide_cnt = collide_cnt_q;

endmodule
